// File: rtl/tile_pixel_engine.sv
// Tile pixel engine: scan-converts edge/depth descriptors into a depth-tested,
// ping-pong tile buffer, LANES pixels per cycle, and flushes tiles pixel-serially.
module tile_pixel_engine #(
    parameter int TILE_W     = 8,
    parameter int TILE_H     = 8,
    parameter int LANES      = 2,
    parameter int EW         = 32,
    parameter int ZW         = 32,
    parameter int COLOR_W    = 8,
    parameter int TIDX_W     = 6,
    parameter int COORD_W    = 10,
    parameter int DEPTH_FUNC = 0,
    parameter int EDGE_INCL  = 0,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic                in_last,
    input  logic [TIDX_W-1:0]   in_tile_x,
    input  logic [TIDX_W-1:0]   in_tile_y,
    input  logic [COLOR_W-1:0]  in_color,
    input  logic [3*EW-1:0]     in_edge,
    input  logic [3*EW-1:0]     in_dex,
    input  logic [3*EW-1:0]     in_dey,
    input  logic [ZW-1:0]       in_z,
    input  logic [ZW-1:0]       in_dzdx,
    input  logic [ZW-1:0]       in_dzdy,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [COLOR_W-1:0]  out_color,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y
);

    localparam int NPIX = TILE_W * TILE_H;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW   = AW - CW;

    typedef enum logic [1:0] {P_IDLE, P_RUN, P_SWAP} pstate_t;
    typedef enum logic {F_IDLE, F_RUN} fstate_t;

    pstate_t pstate_q, pstate_d;
    fstate_t fstate_q, fstate_d;

    logic                     pbank_q, pbank_d;
    logic [COLOR_W-1:0]       color_q, color_d;
    logic                     last_q, last_d;
    logic [TIDX_W-1:0]        tx_q, tx_d, ty_q, ty_d;
    logic signed [EW-1:0]     dex_q [3], dex_d [3];
    logic signed [EW-1:0]     dey_q [3], dey_d [3];
    logic signed [EW-1:0]     row_e_q [3], row_e_d [3];
    logic signed [EW-1:0]     col_e_q [3], col_e_d [3];
    logic [ZW-1:0]            dzdx_q, dzdx_d, dzdy_q, dzdy_d;
    logic [ZW-1:0]            row_z_q, row_z_d, col_z_q, col_z_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;

    logic [AW-1:0]            fidx_q, fidx_d;
    logic [TIDX_W-1:0]        ftx_q, ftx_d, fty_q, fty_d;

    logic [ZW-1:0]            mem_depth_q [2][NPIX];
    logic [ZW-1:0]            mem_depth_d [2][NPIX];
    logic [COLOR_W-1:0]       mem_color_q [2][NPIX];
    logic [COLOR_W-1:0]       mem_color_d [2][NPIX];
    logic                     mem_wr_q [2][NPIX];
    logic                     mem_wr_d [2][NPIX];

    logic                     fbank;
    logic [NPIX-1:0]          wvec_p, wvec_f;
    logic [AW:0]              swap_nxt, flush_nxt;
    logic [AW-1:0]            lidx;
    logic                     cov, zpass;
    logic signed [EW-1:0]     ev;
    logic [ZW-1:0]            zl, zs;

    assign fbank = ~pbank_q;

    // Lowest flushable entry at or after start; MSB flags that one exists.
    function automatic logic [AW:0] next_entry(input logic [NPIX-1:0] w,
                                               input int start);
        logic [AW:0] r;
        r = '0;
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (i >= start && (SKIP_EMPTY == 0 || w[i])) begin
                r = {1'b1, AW'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        pstate_d    = pstate_q;
        fstate_d    = fstate_q;
        pbank_d     = pbank_q;
        color_d     = color_q;
        last_d      = last_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        dex_d       = dex_q;
        dey_d       = dey_q;
        row_e_d     = row_e_q;
        col_e_d     = col_e_q;
        dzdx_d      = dzdx_q;
        dzdy_d      = dzdy_q;
        row_z_d     = row_z_q;
        col_z_d     = col_z_q;
        col_d       = col_q;
        row_d       = row_q;
        fidx_d      = fidx_q;
        ftx_d       = ftx_q;
        fty_d       = fty_q;
        mem_depth_d = mem_depth_q;
        mem_color_d = mem_color_q;
        mem_wr_d    = mem_wr_q;
        lidx        = '0;
        cov         = 1'b0;
        zpass       = 1'b0;
        ev          = '0;
        zl          = '0;
        zs          = '0;
        for (int i = 0; i < NPIX; i++) begin
            wvec_p[i] = mem_wr_q[pbank_q][i];
            wvec_f[i] = mem_wr_q[fbank][i];
        end
        swap_nxt  = next_entry(wvec_p, 0);
        flush_nxt = next_entry(wvec_f, int'(fidx_q) + 1);

        unique case (pstate_q)
            P_IDLE: begin
                if (in_vld) begin
                    color_d = in_color;
                    last_d  = in_last;
                    tx_d    = in_tile_x;
                    ty_d    = in_tile_y;
                    for (int i = 0; i < 3; i++) begin
                        dex_d[i]   = in_dex[i*EW +: EW];
                        dey_d[i]   = in_dey[i*EW +: EW];
                        row_e_d[i] = in_edge[i*EW +: EW];
                        col_e_d[i] = in_edge[i*EW +: EW];
                    end
                    dzdx_d   = in_dzdx;
                    dzdy_d   = in_dzdy;
                    row_z_d  = in_z;
                    col_z_d  = in_z;
                    col_d    = '0;
                    row_d    = '0;
                    pstate_d = P_RUN;
                end
            end
            P_RUN: begin
                for (int k = 0; k < LANES; k++) begin
                    lidx = AW'({row_q, col_q}) + AW'(k);
                    cov  = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        ev = col_e_q[i] + EW'(k) * dex_q[i];
                        if (ev[EW-1] || (EDGE_INCL == 0 && ev == '0)) begin
                            cov = 1'b0;
                        end
                    end
                    zl = col_z_q + ZW'(k) * dzdx_q;
                    zs = mem_depth_q[pbank_q][lidx];
                    if (DEPTH_FUNC == 2) begin
                        zpass = 1'b1;
                    end else if (DEPTH_FUNC == 1) begin
                        zpass = (zl <= zs);
                    end else begin
                        zpass = (zl < zs);
                    end
                    if (cov && zpass) begin
                        mem_depth_d[pbank_q][lidx] = zl;
                        mem_color_d[pbank_q][lidx] = color_q;
                        mem_wr_d[pbank_q][lidx]    = 1'b1;
                    end
                end
                if (col_q == CW'(TILE_W - LANES)) begin
                    col_d   = '0;
                    row_d   = row_q + 1'b1;
                    row_z_d = row_z_q + dzdy_q;
                    col_z_d = row_z_q + dzdy_q;
                    for (int i = 0; i < 3; i++) begin
                        row_e_d[i] = row_e_q[i] + dey_q[i];
                        col_e_d[i] = row_e_q[i] + dey_q[i];
                    end
                    if (row_q == RW'(TILE_H - 1)) begin
                        pstate_d = last_q ? P_SWAP : P_IDLE;
                    end
                end else begin
                    col_d   = col_q + CW'(LANES);
                    col_z_d = col_z_q + ZW'(LANES) * dzdx_q;
                    for (int i = 0; i < 3; i++) begin
                        col_e_d[i] = col_e_q[i] + EW'(LANES) * dex_q[i];
                    end
                end
            end
            P_SWAP: begin
                if (fstate_q == F_IDLE) begin
                    pbank_d  = ~pbank_q;
                    ftx_d    = tx_q;
                    fty_d    = ty_q;
                    pstate_d = P_IDLE;
                    // An empty tile under SKIP_EMPTY never enters F_RUN.
                    if (swap_nxt[AW]) begin
                        fstate_d = F_RUN;
                        fidx_d   = swap_nxt[AW-1:0];
                    end
                end
            end
            default: pstate_d = P_IDLE;
        endcase

        if (fstate_q == F_RUN && out_rdy) begin
            mem_depth_d[fbank][fidx_q] = '1;
            mem_color_d[fbank][fidx_q] = '0;
            mem_wr_d[fbank][fidx_q]    = 1'b0;
            if (flush_nxt[AW]) begin
                fidx_d = flush_nxt[AW-1:0];
            end else begin
                fstate_d = F_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q <= P_IDLE;
            fstate_q <= F_IDLE;
            pbank_q  <= 1'b0;
            color_q  <= '0;
            last_q   <= 1'b0;
            tx_q     <= '0;
            ty_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                dex_q[i]   <= '0;
                dey_q[i]   <= '0;
                row_e_q[i] <= '0;
                col_e_q[i] <= '0;
            end
            dzdx_q   <= '0;
            dzdy_q   <= '0;
            row_z_q  <= '0;
            col_z_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fidx_q   <= '0;
            ftx_q    <= '0;
            fty_q    <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPIX; i++) begin
                    mem_depth_q[b][i] <= '1;
                    mem_color_q[b][i] <= '0;
                    mem_wr_q[b][i]    <= 1'b0;
                end
            end
        end else begin
            pstate_q    <= pstate_d;
            fstate_q    <= fstate_d;
            pbank_q     <= pbank_d;
            color_q     <= color_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            dex_q       <= dex_d;
            dey_q       <= dey_d;
            row_e_q     <= row_e_d;
            col_e_q     <= col_e_d;
            dzdx_q      <= dzdx_d;
            dzdy_q      <= dzdy_d;
            row_z_q     <= row_z_d;
            col_z_q     <= col_z_d;
            col_q       <= col_d;
            row_q       <= row_d;
            fidx_q      <= fidx_d;
            ftx_q       <= ftx_d;
            fty_q       <= fty_d;
            mem_depth_q <= mem_depth_d;
            mem_color_q <= mem_color_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign in_rdy    = (pstate_q == P_IDLE);
    assign out_vld   = (fstate_q == F_RUN);
    assign out_color = out_vld ? mem_color_q[fbank][fidx_q] : '0;
    assign out_x     = out_vld ? COORD_W'(ftx_q) * COORD_W'(TILE_W)
                               + COORD_W'(fidx_q[CW-1:0]) : '0;
    assign out_y     = out_vld ? COORD_W'(fty_q) * COORD_W'(TILE_H)
                               + COORD_W'(fidx_q[AW-1:CW]) : '0;

endmodule

// File: tb/tb_tile_pixel_engine.sv
// Scoreboard bench: dut 0 = LESS/strict/no-skip, dut 1 = LEQUAL/inclusive/skip-empty.
module tb_tile_pixel_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_vld [2];
    logic        in_rdy [2];
    logic        in_last;
    logic [5:0]  in_tile_x, in_tile_y;
    logic [7:0]  in_color;
    logic [95:0] in_edge, in_dex, in_dey;
    logic [31:0] in_z, in_dzdx, in_dzdy;
    logic        out_vld [2];
    logic        out_rdy [2];
    logic [7:0]  out_color [2];
    logic [9:0]  out_x [2];
    logic [9:0]  out_y [2];

    tile_pixel_engine #(.DEPTH_FUNC(0), .EDGE_INCL(0), .SKIP_EMPTY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .in_last(in_last),
        .in_tile_x(in_tile_x), .in_tile_y(in_tile_y), .in_color(in_color),
        .in_edge(in_edge), .in_dex(in_dex), .in_dey(in_dey),
        .in_z(in_z), .in_dzdx(in_dzdx), .in_dzdy(in_dzdy),
        .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .out_color(out_color[0]),
        .out_x(out_x[0]), .out_y(out_y[0])
    );

    tile_pixel_engine #(.DEPTH_FUNC(1), .EDGE_INCL(1), .SKIP_EMPTY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .in_last(in_last),
        .in_tile_x(in_tile_x), .in_tile_y(in_tile_y), .in_color(in_color),
        .in_edge(in_edge), .in_dex(in_dex), .in_dey(in_dey),
        .in_z(in_z), .in_dzdx(in_dzdx), .in_dzdy(in_dzdy),
        .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .out_color(out_color[1]),
        .out_x(out_x[1]), .out_y(out_y[1])
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit gap_en = 0;
    always @(posedge clk) cyc++;

    logic [27:0] q0[$];
    logic [27:0] q1[$];
    logic [31:0] mz [2][64];
    logic [7:0]  mc [2][64];
    bit          mw [2][64];

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [27:0] qpop(input int g);
        if (g == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic logic [95:0] pk3(input logic [31:0] a, b, c);
        return {c, b, a};
    endfunction

    task automatic model_clear(input int d);
        for (int i = 0; i < 64; i++) begin
            mz[d][i] = '1;
            mc[d][i] = '0;
            mw[d][i] = 0;
        end
    endtask

    // Direct per-pixel evaluation of the plane equations.
    task automatic model_apply(input int d);
        logic [31:0] ev, zv;
        bit cov;
        int idx;
        logic [27:0] beat;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                idx = y * 8 + x;
                cov = 1;
                for (int i = 0; i < 3; i++) begin
                    ev = in_edge[i*32 +: 32] + 32'(x) * in_dex[i*32 +: 32]
                       + 32'(y) * in_dey[i*32 +: 32];
                    if (d == 0 ? !($signed(ev) > 0) : !($signed(ev) >= 0)) cov = 0;
                end
                zv = in_z + 32'(x) * in_dzdx + 32'(y) * in_dzdy;
                if (cov && (d == 0 ? (zv < mz[d][idx]) : (zv <= mz[d][idx]))) begin
                    mz[d][idx] = zv;
                    mc[d][idx] = in_color;
                    mw[d][idx] = 1;
                end
            end
        end
        if (in_last) begin
            for (int i = 0; i < 64; i++) begin
                if (d == 0 || mw[d][i]) begin
                    beat = {mc[d][i], 10'(in_tile_x * 8 + i % 8),
                            10'(in_tile_y * 8 + i / 8)};
                    if (d == 0) q0.push_back(beat);
                    else q1.push_back(beat);
                end
            end
            model_clear(d);
        end
    endtask

    task automatic send(input int d, input logic [5:0] tx, ty,
                        input logic [7:0] c, input logic [95:0] e, dx, dy,
                        input logic [31:0] z, zx, zy, input logic last);
        int t;
        in_tile_x = tx; in_tile_y = ty; in_color = c;
        in_edge = e; in_dex = dx; in_dey = dy;
        in_z = z; in_dzdx = zx; in_dzdy = zy; in_last = last;
        in_vld[d] = 1'b1;
        t = 0;
        while (!in_rdy[d] && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("accept_timeout", t < 2000, 1);
        @(posedge clk); #1;
        model_apply(d);
        in_vld[d] = 1'b0;
    endtask

    task automatic wait_vld(input int d);
        int t = 0;
        while (!out_vld[d] && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("vld_timeout", t < 500, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || out_vld[0] || out_vld[1])
               && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_timeout", t < 5000, 1);
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        logic        pv = 1'b0;
        logic        pr = 1'b1;
        logic [27:0] pd, cur, e;
        int          nb = 0;
        int          lc = 0;
        always @(negedge clk) begin
            cur = {out_color[g], out_x[g], out_y[g]};
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b1;
            end else begin
                if (pv && !pr) begin
                    chk("hold_vld", out_vld[g], 1);
                    chk("hold_data", cur, pd);
                end
                if (!gap_en) nb = 0;
                if (out_vld[g] && out_rdy[g]) begin
                    if (qsize(g) == 0) begin
                        chk("extra_beat", {g[0], cur}, {g[0], 28'h0});
                    end else begin
                        e = qpop(g);
                        chk("pixel", cur, e);
                    end
                    if (g == 0 && gap_en) begin
                        if (nb > 0) chk("beat_gap", cyc - lc, 1);
                        nb++;
                        lc = cyc;
                    end
                end
                pv = out_vld[g];
                pr = out_rdy[g];
                pd = cur;
            end
        end
    end

    logic [95:0] full;
    logic [3:0]  pat;

    initial begin
        full = pk3(100, 100, 100);
        pat  = 4'b1001;
        rst_n = 1'b0;
        in_vld[0] = 0; in_vld[1] = 0;
        out_rdy[0] = 1; out_rdy[1] = 1;
        in_last = 0; in_tile_x = 0; in_tile_y = 0; in_color = 0;
        in_edge = 0; in_dex = 0; in_dey = 0;
        in_z = 0; in_dzdx = 0; in_dzdy = 0;
        model_clear(0);
        model_clear(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_rdy", in_rdy[d], 1);
            chk("rst_out_vld", out_vld[d], 0);
            chk("rst_out_data", {out_color[d], out_x[d], out_y[d]}, 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-coverage tile (2,1), consecutive beats on dut 0.
        gap_en = 1;
        send(0, 2, 1, 8'h5A, full, 0, 0, 10, 0, 0, 1);
        send(1, 2, 1, 8'h5A, full, 0, 0, 10, 0, 0, 1);
        drain();
        gap_en = 0;

        // Equal depth: LESS keeps the first, LEQUAL takes the second.
        for (int d = 0; d < 2; d++) begin
            send(d, 0, 0, 8'h11, full, 0, 0, 50, 0, 0, 0);
            send(d, 0, 0, 8'h22, full, 0, 0, 50, 0, 0, 1);
        end
        drain();

        // Edge 0 crosses zero at column 3.
        for (int d = 0; d < 2; d++) begin
            send(d, 1, 0, 8'h3C, pk3(-3, 100, 100), pk3(1, 0, 0), 0,
                 20, 0, 0, 1);
        end
        drain();

        // Backpressure 1,0,0,1 with a depth ramp.
        send(0, 4, 3, 8'h33, full, 0, 0, 5, 1, 8, 1);
        for (int c = 0; c < 320; c++) begin
            out_rdy[0] = pat[c % 4];
            @(posedge clk); #1;
        end
        out_rdy[0] = 1;
        drain();

        // Overlap: tile B shades while tile A's flush is stalled.
        out_rdy[0] = 0;
        send(0, 5, 5, 8'hA5, full, 0, 0, 7, 0, 0, 1);
        wait_vld(0);
        send(0, 6, 5, 8'h44, pk3(-3, 100, 100), pk3(1, 0, 0), 0,
             9, 0, 0, 0);
        send(0, 6, 5, 8'h45, pk3(100, 100, -5), 0, pk3(0, 0, 1),
             3, 0, 0, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("swap_stall_rdy", in_rdy[0], 0);
        chk("a_still_valid", out_vld[0], 1);
        chk("a_beats_left", q0.size(), 128);
        out_rdy[0] = 1;
        drain();
        chk("rdy_after_swap", in_rdy[0], 1);

        // Single covered pixel (5,6) with skip-empty.
        send(1, 0, 0, 8'h99, pk3(-9, -11, 23), pk3(2, 0, -2), pk3(0, 2, -2),
             10, 0, 0, 1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("skip_idle", out_vld[1], 0);

        // Reset during a run while a flush is stalled.
        out_rdy[0] = 0;
        send(0, 2, 2, 8'h66, full, 0, 0, 1, 0, 0, 1);
        wait_vld(0);
        send(0, 3, 2, 8'h77, full, 0, 0, 1, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", out_vld[0], 0);
        chk("midrst_in_rdy", in_rdy[0], 1);
        chk("midrst_out_data", {out_color[0], out_x[0], out_y[0]}, 0);
        q0.delete();
        q1.delete();
        model_clear(0);
        model_clear(1);
        out_rdy[0] = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 3, 2, 8'h12, pk3(-1, -1, -1), 0, 0, 1, 0, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
